// File: rtl/sar_value_finder.sv
// Successive-approximation search engine: drives trial values into a magnitude
// comparator and converges on the hidden target MSB first.
module sar_value_finder #(
    parameter int WIDTH = 3,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             aGTb,
    input  logic             aEQb,
    input  logic             aLTb,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [CW-1:0]    probes
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IW-1:0]    TOP_BIT  = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    probes_q, probes_d;
    logic             error_q, error_d;

    logic             flags_onehot;
    logic [IW-1:0]    bit_dn;
    logic [WIDTH-1:0] trial;

    always_comb begin
        flags_onehot = ({aGTb, aEQb, aLTb} == 3'b100) ||
                       ({aGTb, aEQb, aLTb} == 3'b010) ||
                       ({aGTb, aEQb, aLTb} == 3'b001);
        bit_dn = bit_q - IW'(1);
        // Current guess with the bit under test resolved by the GT/LT answer.
        trial         = guess_q;
        trial[bit_q]  = aGTb;
    end

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        result_d = result_q;
        bit_d    = bit_q;
        probes_d = probes_q;
        error_d  = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_PROBE;
                    guess_d  = MSB_ONLY;
                    bit_d    = TOP_BIT;
                    probes_d = '0;
                end
            end

            S_PROBE: begin
                probes_d = probes_q + CW'(1);
                if (!flags_onehot) begin
                    error_d  = 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end else if (aEQb) begin
                    error_d  = 1'b0;
                    result_d = guess_q;
                    state_d  = S_DONE;
                end else if (bit_q == '0) begin
                    error_d  = 1'b0;
                    result_d = trial;
                    state_d  = S_DONE;
                end else begin
                    guess_d         = trial;
                    guess_d[bit_dn] = 1'b1;
                    bit_d           = bit_dn;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            guess_q  <= '0;
            result_q <= '0;
            bit_q    <= '0;
            probes_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            bit_q    <= bit_d;
            probes_q <= probes_d;
            error_q  <= error_d;
        end
    end

    assign guess  = guess_q;
    assign busy   = (state_q == S_PROBE);
    assign done   = (state_q == S_DONE);
    assign error  = error_q;
    assign result = result_q;
    assign probes = probes_q;

endmodule

// File: tb/tb_sar_value_finder.sv
// Bench for sar_value_finder: a behavioural comparator answers the probes,
// table vectors plus randomized targets/flag faults check result, probes, latency.
module tb_sar_value_finder;

    localparam int W   = 3;
    localparam int CWP = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic           aGTb, aEQb, aLTb;
    logic [W-1:0]   guess, result;
    logic           busy, done, error;
    logic [CWP-1:0] probes;

    logic [W-1:0]   tgt = '0;
    logic           bad = 1'b0;
    logic [2:0]     bad_pat = 3'b000;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] gseq[$];
    int r_res, r_prb, r_err, r_lat;
    bit r_seen;

    typedef struct {
        int         target;
        int         bad_at;
        logic [2:0] pat;
        int         e_res;
        int         e_prb;
        int         e_err;
        int         e_lat;
    } vec_t;

    vec_t vecs[11];
    logic [2:0] bad_pats[5];

    always #5 clk = ~clk;

    // Comparator with target on valA, guess on valB; optionally corrupted.
    always_comb begin
        if (bad) begin
            {aGTb, aEQb, aLTb} = bad_pat;
        end else begin
            aGTb = (tgt > guess);
            aEQb = (tgt == guess);
            aLTb = (tgt < guess);
        end
    end

    sar_value_finder #(.WIDTH(W), .CW(CWP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .aGTb   (aGTb),
        .aEQb   (aEQb),
        .aLTb   (aLTb),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .result (result),
        .probes (probes)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Launch one search; bad_at selects the probe (1-based) with corrupted flags.
    task automatic run(input int target, input int bad_at, input logic [2:0] pat,
                       input bit keep_start);
        tgt     = W'(target);
        bad     = 1'b0;
        bad_pat = pat;
        gseq.delete();
        r_seen  = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) start = 1'b0;
        for (int cyc = 1; cyc <= W + 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                r_seen = 1;
                r_lat  = cyc;
                r_res  = int'(result);
                r_prb  = int'(probes);
                r_err  = int'(error);
                break;
            end
            gseq.push_back(guess);
            bad = (cyc == bad_at);
        end
        bad = 1'b0;
        if (!r_seen) chk("done_timeout", 0, 1);
    endtask

    // Reference: without faults the search ends at the lowest set bit of the
    // target (EQ hit) or after all WIDTH bits for target 0.
    function automatic int ref_probes(input int t);
        int tz;
        tz = 0;
        if (t == 0) return W;
        while (((t >> tz) & 1) == 0) tz++;
        return W - tz;
    endfunction

    task automatic chk_seq(input string name, input int a, input int b, input int c);
        chk({name, "_len"}, gseq.size(), 3);
        if (gseq.size() == 3) begin
            chk({name, "_g0"}, int'(gseq[0]), a);
            chk({name, "_g1"}, int'(gseq[1]), b);
            chk({name, "_g2"}, int'(gseq[2]), c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dones;
        int t, np, ba, er, rr, pp, ll;
        logic [2:0] pt;

        vecs[0]  = '{5, 0, 3'b000, 5, 3, 0, 4};
        vecs[1]  = '{4, 0, 3'b000, 4, 1, 0, 2};
        vecs[2]  = '{0, 0, 3'b000, 0, 3, 0, 4};
        vecs[3]  = '{7, 0, 3'b000, 7, 3, 0, 4};
        vecs[4]  = '{3, 0, 3'b000, 3, 3, 0, 4};
        vecs[5]  = '{1, 0, 3'b000, 1, 3, 0, 4};
        vecs[6]  = '{2, 0, 3'b000, 2, 2, 0, 3};
        vecs[7]  = '{6, 0, 3'b000, 6, 2, 0, 3};
        vecs[8]  = '{5, 2, 3'b101, 0, 2, 1, 3};
        vecs[9]  = '{6, 1, 3'b000, 0, 1, 1, 2};
        vecs[10] = '{1, 3, 3'b111, 0, 3, 1, 4};
        bad_pats = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

        #1 rst_n = 1'b0;
        #10;
        chk("rst_guess",  int'(guess), 0);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_done",   int'(done), 0);
        chk("rst_error",  int'(error), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_probes", int'(probes), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run(vecs[i].target, vecs[i].bad_at, vecs[i].pat, 1'b0);
            chk($sformatf("vec%0d_result", i), r_res, vecs[i].e_res);
            chk($sformatf("vec%0d_probes", i), r_prb, vecs[i].e_prb);
            chk($sformatf("vec%0d_error",  i), r_err, vecs[i].e_err);
            chk($sformatf("vec%0d_latency", i), r_lat, vecs[i].e_lat);
        end

        run(5, 0, 3'b000, 1'b0);
        chk_seq("seq5", 4, 6, 5);
        run(0, 0, 3'b000, 1'b0);
        chk_seq("seq0", 4, 2, 1);
        run(7, 0, 3'b000, 1'b0);
        chk_seq("seq7", 4, 6, 7);

        // Result, probes and guess hold through IDLE.
        @(negedge clk);
        chk("hold_done",   int'(done), 0);
        chk("hold_busy",   int'(busy), 0);
        @(negedge clk);
        chk("hold_result", int'(result), 7);
        chk("hold_probes", int'(probes), 3);
        chk("hold_guess",  int'(guess), 7);

        // Start held high: DONE ignores it, the next IDLE accepts it.
        run(4, 0, 3'b000, 1'b1);
        chk("cont_first_result", r_res, 4);
        @(negedge clk);
        chk("cont_idle_busy", int'(busy), 0);
        chk("cont_idle_done", int'(done), 0);
        @(negedge clk);
        chk("cont_restart_busy",  int'(busy), 1);
        chk("cont_restart_guess", int'(guess), 4);
        @(negedge clk);
        chk("cont_second_done", int'(done), 1);
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        chk("cont_done_count", dones, 4);
        @(negedge clk);

        // Asynchronous reset in the middle of a search.
        tgt = 3'd5;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("mid_busy_before", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_guess",  int'(guess), 0);
        chk("mid_rst_busy",   int'(busy), 0);
        chk("mid_rst_done",   int'(done), 0);
        chk("mid_rst_error",  int'(error), 0);
        chk("mid_rst_result", int'(result), 0);
        chk("mid_rst_probes", int'(probes), 0);
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("mid_rst_no_done", dones, 0);
        rst_n = 1'b1;
        run(3, 0, 3'b000, 1'b0);
        chk("post_rst_result", r_res, 3);
        chk("post_rst_probes", r_prb, 3);
        chk("post_rst_error",  r_err, 0);

        for (int k = 0; k < 40; k++) begin
            t  = $urandom_range(0, 7);
            np = ref_probes(t);
            ba = ($urandom_range(0, 1) == 1) ? $urandom_range(1, np) : 0;
            pt = bad_pats[$urandom_range(0, 4)];
            if (ba != 0) begin
                rr = 0; pp = ba; er = 1; ll = ba + 1;
            end else begin
                rr = t; pp = np; er = 0; ll = np + 1;
            end
            run(t, ba, pt, 1'b0);
            chk($sformatf("rnd%0d_t%0d_result", k, t), r_res, rr);
            chk($sformatf("rnd%0d_t%0d_probes", k, t), r_prb, pp);
            chk($sformatf("rnd%0d_t%0d_error",  k, t), r_err, er);
            chk($sformatf("rnd%0d_t%0d_latency", k, t), r_lat, ll);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
